// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter and read gate for a shared 8-bit fifo.
// Producers win whole bursts of up to BURST words; reads and writes are gated on fifo status.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned BURST     = 4,
    parameter int unsigned MAX_DATA  = 16,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [8*NREQ-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    input  logic                     rd_req,
    output logic                     rd_ok,
    input  logic                     fifo_full,
    input  logic                     fifo_empty,
    input  logic [ADDR_BITS:0]       fifo_count,
    output logic                     fifo_wen,
    output logic [7:0]               fifo_wdata,
    output logic                     fifo_ren
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [OW-1:0]   winner;
    logic            winner_found;
    logic [OW-1:0]   next_ptr;
    logic            can_wr;

    // rst_n gates the read strobe so it drops the instant reset asserts.
    assign fifo_ren = rst_n && rd_req && !fifo_empty;
    assign rd_ok    = fifo_ren;
    assign can_wr   = !fifo_full || fifo_ren;

    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    // Scan from high offset down so the lowest offset from rr_ptr is the last to win.
    always_comb begin
        int unsigned idx;
        winner_found = 1'b0;
        winner       = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (req[OW'(idx)]) begin
                winner_found = 1'b1;
                winner       = OW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        gnt      = '0;
        unique case (state_q)
            StIdle: begin
                if (winner_found) begin
                    owner_d = winner;
                    beat_d  = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (!req[owner_q]) begin
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end else if (can_wr) begin
                    gnt[owner_q] = 1'b1;
                    beat_d       = beat_q + BW'(1);
                    if (req_last[owner_q] || beat_q == BW'(BURST - 1)) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

    assign busy       = (state_q == StBurst);
    assign owner      = owner_q;
    assign fifo_wen   = |gnt;
    assign fifo_wdata = req_data[8*int'(owner_q) +: 8];

`ifdef FORMAL
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_wen_safe:   assert property (@(posedge clk) disable iff (!rst_n)
                                   fifo_wen |-> (!fifo_full || fifo_ren));
    a_ren_safe:   assert property (@(posedge clk) disable iff (!rst_n) fifo_ren |-> !fifo_empty);
    a_count_max:  assert property (@(posedge clk) disable iff (!rst_n)
                                   fifo_count <= (ADDR_BITS + 1)'(MAX_DATA));
    a_gnt_busy:   assert property (@(posedge clk) disable iff (!rst_n) !busy |-> (gnt == '0));

    // Count foreign tenure starts seen by each continuously requesting producer.
    for (genvar g = 0; g < NREQ; g++) begin : g_fair
        logic [7:0] wait_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wait_q <= '0;
            end else if (!req[g]) begin
                wait_q <= '0;
            end else if (state_q == StIdle && state_d == StBurst) begin
                wait_q <= (owner_d == OW'(g)) ? 8'd0 : wait_q + 8'd1;
            end
        end
        a_fair: assert property (@(posedge clk) disable iff (!rst_n) wait_q <= 8'(NREQ));
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level model
// of the arbiter and a queue-based fifo.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int BURST    = 4;
    localparam int MAX_DATA = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_last;
    logic [NREQ-1:0]  gnt;
    logic [1:0]       owner;
    logic             busy;
    logic             rd_req;
    logic             rd_ok;
    logic             fifo_full;
    logic             fifo_empty;
    logic [5:0]       fifo_count;
    logic             fifo_wen;
    logic [7:0]       fifo_wdata;
    logic             fifo_ren;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .BURST     (BURST),
        .MAX_DATA  (MAX_DATA),
        .ADDR_BITS (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .owner      (owner),
        .busy       (busy),
        .rd_req     (rd_req),
        .rd_ok      (rd_ok),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .fifo_ren   (fifo_ren)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: tenure flag, owner, next scan start, words accepted in this tenure.
    bit          m_busy;
    int          m_owner;
    int          m_rr;
    int          m_words;
    logic [7:0]  fifo_q[$];
    logic [NREQ-1:0] r_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_rr    = 0;
        m_words = 0;
        fifo_q.delete();
    endtask

    task automatic drive_fifo_status();
        fifo_full  = (fifo_q.size() == MAX_DATA);
        fifo_empty = (fifo_q.size() == 0);
        fifo_count = 6'(fifo_q.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; req_last = '0; rd_req = 1'b0; req_data = '0;
        model_reset();
        drive_fifo_status();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, compare combinational outputs, then advance the model.
    task automatic step(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] d,
                        input logic [NREQ-1:0] l, input logic rd);
        logic            e_ren, e_can;
        logic [NREQ-1:0] e_gnt;
        bit              found;
        int              c;
        @(negedge clk);
        req = r; req_data = d; req_last = l; rd_req = rd;
        drive_fifo_status();
        #1;
        e_ren = rd && (fifo_q.size() > 0);
        e_can = (fifo_q.size() < MAX_DATA) || e_ren;
        e_gnt = '0;
        if (m_busy && r[m_owner] && e_can) e_gnt[m_owner] = 1'b1;
        check("busy", 32'(busy), 32'(m_busy));
        check("owner", 32'(owner), 32'(m_owner));
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("fifo_wen", 32'(fifo_wen), 32'(|e_gnt));
        check("fifo_ren", 32'(fifo_ren), 32'(e_ren));
        check("rd_ok", 32'(rd_ok), 32'(e_ren));
        if (|e_gnt) check("fifo_wdata", 32'(fifo_wdata), 32'(d[8*m_owner +: 8]));
        if (e_ren) void'(fifo_q.pop_front());
        if (|e_gnt) fifo_q.push_back(d[8*m_owner +: 8]);
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_rr + k) % NREQ;
                if (!found && r[c]) begin
                    found = 1'b1; m_busy = 1'b1; m_owner = c; m_words = 0;
                end
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % NREQ;
        end else if (|e_gnt) begin
            m_words++;
            if (l[m_owner] || m_words == BURST) begin
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic step_random();
        logic [NREQ-1:0] l;
        for (int i = 0; i < NREQ; i++) begin
            if (r_hold[i]) r_hold[i] = ($urandom_range(7) != 0);
            else           r_hold[i] = ($urandom_range(2) == 0);
            l[i] = ($urandom_range(4) == 0);
        end
        step(r_hold, {$urandom, $urandom} >> 0, l, $urandom_range(1) == 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; req_data = '0; req_last = '0; rd_req = 1'b0;
        r_hold = '0;
        model_reset();
        drive_fifo_status();

        // Reset values and blocked read on an empty fifo, then write-then-read.
        do_reset();
        step(4'b0000, 32'h0, 4'b0000, 1'b1);
        check("ren_empty", 32'(fifo_ren), 32'd0);
        step(4'b0001, 32'h0000_0055, 4'b0001, 1'b1);
        step(4'b0001, 32'h0000_0055, 4'b0001, 1'b1);
        step(4'b0000, 32'h0, 4'b0000, 1'b1);
        check("ren_after_wr", 32'(fifo_ren), 32'd1);

        // Reset mid-burst: producer 1 at beat 2.
        do_reset();
        repeat (3) step(4'b0010, $urandom, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_gnt", 32'(gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_wen", 32'(fifo_wen), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, $urandom, 4'b0000, 1'b0);
        step(4'b1111, $urandom, 4'b0000, 1'b0);
        check("rr_after_rst", 32'(owner), 32'd0);

        // Round robin with all requesting: 4 full bursts, then stall on full, then drain.
        do_reset();
        repeat (28) step(4'b1111, {$urandom, $urandom} >> 0, 4'b0000, 1'b0);
        check("full_stall_gnt", 32'(gnt), 32'd0);
        repeat (20) step(4'b1111, {$urandom, $urandom} >> 0, 4'b0000, 1'b1);

        // Early packet end from producer 2.
        do_reset();
        step(4'b0100, 32'h0, 4'b0000, 1'b0);
        step(4'b0100, 32'h00A1_0000, 4'b0000, 1'b0);
        step(4'b0100, 32'h00A2_0000, 4'b0100, 1'b0);
        step(4'b1111, 32'h0, 4'b0000, 1'b0);
        step(4'b1111, 32'h0, 4'b0000, 1'b0);
        check("early_next_owner", 32'(owner), 32'd3);

        // Abandon by producer 3 after one word.
        do_reset();
        step(4'b1000, 32'h0, 4'b0000, 1'b0);
        step(4'b1000, 32'h3300_0000, 4'b0000, 1'b0);
        step(4'b0000, 32'h0, 4'b0000, 1'b0);
        step(4'b1001, 32'h0, 4'b0000, 1'b0);
        step(4'b1001, 32'h0, 4'b0000, 1'b0);
        check("abandon_owner", 32'(owner), 32'd0);

        // Long randomized run.
        do_reset();
        repeat (3000) step_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter and read gate for the shared 8-bit `fifo`; sits directly in front of one fifo instance.
- Shares the single write port between NREQ producers, granting whole bursts of up to BURST words per producer.
- Gates reads and writes on fifo status so the fifo's overwrite-on-full and read-on-empty skip paths are never exercised.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- BURST, 4, maximum accepted words per grant tenure (1..MAX_DATA).
- MAX_DATA, 16, fifo depth; must match the fifo instance.
- ADDR_BITS, 5, fifo address width; count width is ADDR_BITS+1.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-producer write request; data valid while high.
- req_data  in  8*NREQ  producer words; producer i uses bits [8i+7:8i].
- req_last  in  NREQ  marks the final word of a producer packet.
- gnt  out  NREQ  one-hot; word accepted this cycle from producer i.
- owner  out  $clog2(NREQ)  index of the current burst owner.
- busy  out  1  burst tenure active.
- rd_req  in  1  consumer read request.
- rd_ok  out  1  read performed this cycle (equals fifo_ren).
- fifo_full  in  1  from fifo.
- fifo_empty  in  1  from fifo.
- fifo_count  in  ADDR_BITS+1  from fifo; used for formal checks only.
- fifo_wen  out  1  to fifo.
- fifo_wdata  out  8  to fifo.
- fifo_ren  out  1  to fifo.

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - Registers: state=IDLE, owner=0, rr_ptr=0, beat=0.
  - Outputs: busy=0, gnt=0, fifo_wen=0, fifo_ren=0.
  - All outputs are forced to these values immediately when rst_n falls, including mid-burst.
- Read gating: fifo_ren = rd_req && !fifo_empty (combinational); rd_ok = fifo_ren.
- Write acceptance: can_wr = !fifo_full || fifo_ren. A write while full is legal only when paired with a read, which leaves the fifo count unchanged.
- State IDLE:
  - Scan req starting at rr_ptr, wrapping modulo NREQ; the first asserted requester wins.
  - If a winner exists: owner<=winner, beat<=0, state<=BURST on the next edge.
  - No grant is issued in IDLE; this costs a 1-cycle arbitration latency.
  - busy=0.
- State BURST:
  - busy=1.
  - gnt[owner] = req[owner] && can_wr, combinational; all other gnt bits are 0.
  - fifo_wen = |gnt; fifo_wdata = req_data slice of owner, muxed combinationally.
  - On an accepted word: beat<=beat+1.
  - Exit to IDLE on the accepted word if req_last[owner]=1 or beat==BURST-1.
  - Also exit to IDLE (abandon) if req[owner]=0 in any BURST cycle; nothing is written in that cycle.
  - On any exit: rr_ptr<=(owner+1) mod NREQ.
  - A full fifo stalls the burst: BURST is held, gnt stays 0, beat is unchanged, and no timeout applies.
- Width rules:
  - beat is $clog2(BURST+1) bits and never exceeds BURST-1 at the compare.
  - rr_ptr and owner wrap from NREQ-1 to 0.
- Invariants (asserted under `FORMAL`):
  - gnt is one-hot or zero.
  - fifo_wen implies !fifo_full || fifo_ren.
  - fifo_ren implies !fifo_empty.
  - fifo_count <= MAX_DATA.
  - No gnt while busy=0.
  - Every continuously requesting producer is granted within NREQ tenures.

Test Plan:
- Reset mid-burst: producer 1 owns a burst with beat=2; pulse rst_n low -> busy, gnt, fifo_wen drop immediately; after release owner=0, rr_ptr=0.
- Round-robin fairness: req=4'b1111, all req_last=0, fifo empty, no reads -> tenures owner 0,1,2,3,0 each of 4 words. After 16 words fifo_full=1 and all gnt stay 0.
- Early packet end: producer 2 sends 0xA1,0xA2 with req_last on the second word -> exactly 2 fifo writes, then IDLE; next scan starts at producer 3.
- Full with simultaneous read: fifo at count 16, owner 0 requesting, rd_req=1 -> fifo_wen=1 and fifo_ren=1 in the same cycle, count stays 16. With rd_req=0 -> no write, burst stalls.
- Empty read blocked: fifo empty, rd_req=1 -> fifo_ren=0, rd_ok=0; after one accepted write -> fifo_ren=1 the next cycle and the read returns the written word.
- Abandon: producer 3 drops req after 1 word -> return to IDLE, rr_ptr=0, fifo count +1 only.
